// File: rtl/router_pkg.sv
// Shared router definitions: port indices, default sizes and arbiter FSM encoding.
package router_pkg;

  localparam int DEF_NUM_IN  = 3;
  localparam int DEF_NUM_OUT = 3;

  // Input port indices
  localparam int PE    = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;

  // Output port indices
  localparam int SOUTH  = 0;
  localparam int WEST   = 1;
  localparam int PE_OUT = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_output_arbiter.sv
// One output port: round-robin pick among legal requesters, then hold the grant
// for the owner until its tail flit has been transferred.
module rr_output_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int OUT_IDX = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         i_req_valid,
  input  logic [NUM_IN*NUM_OUT-1:0] i_req_dest,
  input  logic [NUM_IN-1:0]         i_req_tail,
  input  logic                      i_out_ready,
  output logic [NUM_IN-1:0]         o_grant,
  output logic                      o_valid,
  output logic                      o_locked,
  output logic                      o_err
);

  localparam int                   PTR_W    = $clog2(NUM_IN);
  localparam logic [NUM_OUT-1:0]   SEL      = NUM_OUT'(1) << OUT_IDX;
  localparam logic [PTR_W:0]       NUM_IN_W = (PTR_W + 1)'(NUM_IN);
  localparam logic [PTR_W-1:0]     LAST     = PTR_W'(NUM_IN - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [PTR_W-1:0]  r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]  r_owner, w_owner_nxt;
  logic [PTR_W-1:0]  w_winner;
  logic [PTR_W:0]    w_scan;
  logic              w_found;
  logic              w_xfer;
  logic              r_err;
  logic [NUM_IN-1:0] w_cand, w_bad, w_grant;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Matching SEL exactly implies the dest is one-hot, so illegal requests never compete.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_req
    logic [NUM_OUT-1:0] w_dest;
    assign w_dest    = i_req_dest[i*NUM_OUT +: NUM_OUT];
    assign w_cand[i] = i_req_valid[i] && (w_dest == SEL);
    assign w_bad[i]  = i_req_valid[i] && !$onehot(w_dest);
  end

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_scan = {1'b0, r_ptr} + (PTR_W + 1)'(k);
      if (w_scan >= NUM_IN_W) w_scan = w_scan - NUM_IN_W;
      if (!w_found && w_cand[w_scan[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[PTR_W-1:0];
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_grant     = '0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant[w_winner] = 1'b1;
          w_xfer            = i_out_ready;
          if (w_xfer) begin
            if (i_req_tail[w_winner]) begin
              w_ptr_nxt = next_ptr(w_winner);
            end else begin
              w_state_nxt = ST_LOCKED;
              w_owner_nxt = w_winner;
            end
          end
        end
      end
      ST_LOCKED: begin
        w_grant[r_owner] = 1'b1;
        w_xfer           = w_cand[r_owner] && i_out_ready;
        if (w_xfer && i_req_tail[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = next_ptr(r_owner);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_err   <= r_err | (|w_bad);
    end
  end

  // Outputs are forced quiet while reset is held, whatever the requests look like.
  assign o_grant  = reset ? w_grant : '0;
  assign o_valid  = reset & w_xfer;
  assign o_locked = reset & (r_state == ST_LOCKED);
  assign o_err    = r_err;

endmodule

// File: rtl/rr_wormhole_arbiter.sv
// Router output arbitration: one wormhole round-robin arbiter per output port,
// with the per-output grants folded back into per-input acknowledges.
module rr_wormhole_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         req_valid,
  input  logic [NUM_IN*NUM_OUT-1:0] req_dest,
  input  logic [NUM_IN-1:0]         req_tail,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*NUM_IN-1:0] grant,
  output logic [NUM_OUT-1:0]        out_valid,
  output logic [NUM_IN-1:0]         in_ack,
  output logic [NUM_OUT-1:0]        out_locked,
  output logic                      err_dest
);

  logic [NUM_OUT-1:0] w_err;

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    rr_output_arbiter #(
      .NUM_IN  (NUM_IN),
      .NUM_OUT (NUM_OUT),
      .OUT_IDX (o)
    ) u_arb (
      .clk         (clk),
      .reset       (reset),
      .i_req_valid (req_valid),
      .i_req_dest  (req_dest),
      .i_req_tail  (req_tail),
      .i_out_ready (out_ready[o]),
      .o_grant     (grant[o*NUM_IN +: NUM_IN]),
      .o_valid     (out_valid[o]),
      .o_locked    (out_locked[o]),
      .o_err       (w_err[o])
    );
  end

  // A one-hot dest means at most one output can ack a given input per cycle.
  always_comb begin
    in_ack = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        in_ack[i] = in_ack[i] | (out_valid[o] & grant[o*NUM_IN + i]);
      end
    end
  end

  assign err_dest = |w_err;

endmodule

// File: tb/tb_rr_wormhole_arbiter.sv
// Directed-vector bench for rr_wormhole_arbiter (3 inputs x 3 outputs).
module tb_rr_wormhole_arbiter;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req_valid;
  logic [8:0] req_dest;
  logic [2:0] req_tail;
  logic [2:0] out_ready;
  logic [8:0] grant;
  logic [2:0] out_valid;
  logic [2:0] in_ack;
  logic [2:0] out_locked;
  logic       err_dest;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] v;
    logic [8:0] d;
    logic [2:0] t;
    logic [2:0] r;
    logic [8:0] g;
    logic [2:0] a;
    logic [2:0] ov;
    logic [2:0] lk;
  } vec_t;

  vec_t vecs[$];

  rr_wormhole_arbiter #(.NUM_IN(3), .NUM_OUT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_dest   (req_dest),
    .req_tail   (req_tail),
    .out_ready  (out_ready),
    .grant      (grant),
    .out_valid  (out_valid),
    .in_ack     (in_ack),
    .out_locked (out_locked),
    .err_dest   (err_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag, input logic [8:0] g, input logic [2:0] a,
                             input logic [2:0] ov, input logic [2:0] lk, input logic err);
    check({tag, " grant"},      32'(grant),      32'(g));
    check({tag, " in_ack"},     32'(in_ack),     32'(a));
    check({tag, " out_valid"},  32'(out_valid),  32'(ov));
    check({tag, " out_locked"}, 32'(out_locked), 32'(lk));
    check({tag, " err_dest"},   32'(err_dest),   32'(err));
  endtask

  // Drive just after the rising edge, compare on the falling edge.
  task automatic step(input string tag, input logic [2:0] v, input logic [8:0] d,
                      input logic [2:0] t, input logic [2:0] r, input logic [8:0] g,
                      input logic [2:0] a, input logic [2:0] ov, input logic [2:0] lk,
                      input logic err);
    @(posedge clk);
    #1;
    req_valid = v;
    req_dest  = d;
    req_tail  = t;
    out_ready = r;
    @(negedge clk);
    compare_all(tag, g, a, ov, lk, err);
  endtask

  initial begin
    // dest layout: [2:0]=PE, [5:3]=NORTH, [8:6]=EAST; grant layout: [2:0]=SOUTH, [5:3]=WEST, [8:6]=PE_OUT
    vecs.push_back('{3'b000, 9'b000_000_000, 3'b000, 3'b111, 9'b000_000_000, 3'b000, 3'b000, 3'b000});
    vecs.push_back('{3'b010, 9'b000_010_000, 3'b010, 3'b111, 9'b000_010_000, 3'b010, 3'b010, 3'b000});
    vecs.push_back('{3'b000, 9'b000_000_000, 3'b000, 3'b111, 9'b000_000_000, 3'b000, 3'b000, 3'b000});
    vecs.push_back('{3'b101, 9'b010_000_010, 3'b101, 3'b111, 9'b000_100_000, 3'b100, 3'b010, 3'b000});
    vecs.push_back('{3'b101, 9'b010_000_010, 3'b101, 3'b111, 9'b000_001_000, 3'b001, 3'b010, 3'b000});
    vecs.push_back('{3'b111, 9'b001_001_001, 3'b111, 3'b111, 9'b000_000_001, 3'b001, 3'b001, 3'b000});
    vecs.push_back('{3'b111, 9'b001_001_001, 3'b111, 3'b111, 9'b000_000_010, 3'b010, 3'b001, 3'b000});
    vecs.push_back('{3'b111, 9'b001_001_001, 3'b111, 3'b111, 9'b000_000_100, 3'b100, 3'b001, 3'b000});
    vecs.push_back('{3'b111, 9'b001_001_001, 3'b111, 3'b111, 9'b000_000_001, 3'b001, 3'b001, 3'b000});
    vecs.push_back('{3'b111, 9'b001_001_001, 3'b111, 3'b111, 9'b000_000_010, 3'b010, 3'b001, 3'b000});
    vecs.push_back('{3'b111, 9'b001_001_001, 3'b111, 3'b111, 9'b000_000_100, 3'b100, 3'b001, 3'b000});
    for (int k = 0; k < 4; k++)
      vecs.push_back('{3'b010, 9'b000_001_000, 3'b010, 3'b110, 9'b000_000_010, 3'b000, 3'b000, 3'b000});
    vecs.push_back('{3'b010, 9'b000_001_000, 3'b010, 3'b111, 9'b000_000_010, 3'b010, 3'b001, 3'b000});

    // Reset held with every input requesting: all outputs must stay quiet.
    reset     = 1'b0;
    req_valid = 3'b111;
    req_dest  = 9'b100_010_001;
    req_tail  = 3'b111;
    out_ready = 3'b111;
    #3;
    compare_all("in_reset", 9'b0, 3'b0, 3'b0, 3'b0, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 3'b000;

    for (int k = 0; k < vecs.size(); k++)
      step($sformatf("vec%0d", k), vecs[k].v, vecs[k].d, vecs[k].t, vecs[k].r,
           vecs[k].g, vecs[k].a, vecs[k].ov, vecs[k].lk, 1'b0);

    // PE sends a 3-flit packet to WEST with a valid gap while EAST waits on WEST.
    step("pkt_head", 3'b001, 9'b000_000_010, 3'b000, 3'b111, 9'b000_001_000, 3'b001, 3'b010, 3'b000, 1'b0);
    step("pkt_body", 3'b101, 9'b010_000_010, 3'b000, 3'b111, 9'b000_001_000, 3'b001, 3'b010, 3'b010, 1'b0);
    step("pkt_gap",  3'b100, 9'b010_000_010, 3'b000, 3'b111, 9'b000_001_000, 3'b000, 3'b000, 3'b010, 1'b0);
    step("pkt_tail", 3'b101, 9'b010_000_010, 3'b001, 3'b111, 9'b000_001_000, 3'b001, 3'b010, 3'b010, 1'b0);
    step("east_win", 3'b100, 9'b010_000_000, 3'b100, 3'b111, 9'b000_100_000, 3'b100, 3'b010, 3'b000, 1'b0);

    // Reset in the middle of a locked packet drops the lock immediately.
    step("rst_head", 3'b001, 9'b000_000_010, 3'b000, 3'b111, 9'b000_001_000, 3'b001, 3'b010, 3'b000, 1'b0);
    step("rst_body", 3'b001, 9'b000_000_010, 3'b000, 3'b111, 9'b000_001_000, 3'b001, 3'b010, 3'b010, 1'b0);
    #1 reset = 1'b0;
    #1 compare_all("rst_mid", 9'b0, 3'b0, 3'b0, 3'b0, 1'b0);
    reset = 1'b1;
    #1 compare_all("rst_after", 9'b000_001_000, 3'b001, 3'b010, 3'b000, 1'b0);
    req_valid = 3'b000;

    // Illegal destinations are never granted and set the sticky error flag.
    step("err_multi", 3'b010, 9'b000_011_000, 3'b010, 3'b111, 9'b0, 3'b0, 3'b0, 3'b0, 1'b0);
    step("err_zero",  3'b010, 9'b000_000_000, 3'b010, 3'b111, 9'b0, 3'b0, 3'b0, 3'b0, 1'b1);
    step("err_hold1", 3'b000, 9'b000_000_000, 3'b000, 3'b111, 9'b0, 3'b0, 3'b0, 3'b0, 1'b1);
    step("err_hold2", 3'b000, 9'b000_000_000, 3'b000, 3'b111, 9'b0, 3'b0, 3'b0, 3'b0, 1'b1);
    #1 reset = 1'b0;
    #1 check("err_cleared", 32'(err_dest), 32'(0));
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
